wb_arbiter: RTL and testbench

- Shares the single register-file write port (wr_addr/wr_data/wr_valid) between two writeback requesters: the ALU result path and the memory-load path.
- Each requester pushes into its own small FIFO through a valid/ready handshake.
- A round-robin arbiter pops one FIFO head per cycle into a registered write port that drives reg_file directly.
- Exports a per-register pending-write mask that the decoder uses to stall on read-after-write hazards.

---
 rtl/wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths.
// Latency: a push at one edge is popped at the next edge at the earliest; wr_* are registered.
// Backpressure: x_wr_ready drops while that requester's FIFO is full; arbitration is round-robin.
module wb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [W-1:0]         push_dat,
    input  logic                 pop,
    output logic [W-1:0]         head_dat,
    output logic                 head_vld,
    output logic                 rdy,
    output logic [DEPTH*W-1:0]   ent_dat,
    output logic [DEPTH-1:0]     ent_vld
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW-1:0] off;
    logic          do_push;
    logic          do_pop;

    assign rdy      = (count != (PW+1)'(DEPTH));
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_push  = push & rdy;
    assign do_pop   = pop & head_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Payload storage carries no reset; validity comes from pointers and count.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= push_dat;
    end

    always_comb begin
        off     = '0;
        ent_dat = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_dat[i*W +: W] = mem[i];
            off               = PW'(i) - rd_ptr;
            ent_vld[i]        = ({1'b0, off} < count);
        end
    end
endmodule

// Two writeback FIFOs, a round-robin pop arbiter and a registered reg_file write port.
// Latency: two edges minimum from request to reg_file update, no bypass.
// Backpressure: per-source ready = FIFO not full; busy_mask flags every queued or in-flight target.
module wb_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_wr_valid,
    input  logic [ADDR_W-1:0]    alu_wr_addr,
    input  logic [DATA_W-1:0]    alu_wr_data,
    output logic                 alu_wr_ready,
    input  logic                 mem_wr_valid,
    input  logic [ADDR_W-1:0]    mem_wr_addr,
    input  logic [DATA_W-1:0]    mem_wr_data,
    output logic                 mem_wr_ready,
    output logic                 wr_valid,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 wr_src,
    output logic [2**ADDR_W-1:0] busy_mask
);
    localparam int W = ADDR_W + DATA_W;

    logic [W-1:0]            alu_head;
    logic [W-1:0]            mem_head;
    logic                    alu_head_vld;
    logic                    mem_head_vld;
    logic [FIFO_DEPTH*W-1:0] alu_ent;
    logic [FIFO_DEPTH*W-1:0] mem_ent;
    logic [FIFO_DEPTH-1:0]   alu_ent_vld;
    logic [FIFO_DEPTH-1:0]   mem_ent_vld;
    logic                    rr_ptr;
    logic                    grant_alu;
    logic                    grant_mem;
    logic                    any_grant;
    logic [W-1:0]            sel_dat;

    wb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (alu_wr_valid),
        .push_dat ({alu_wr_addr, alu_wr_data}),
        .pop      (grant_alu),
        .head_dat (alu_head),
        .head_vld (alu_head_vld),
        .rdy      (alu_wr_ready),
        .ent_dat  (alu_ent),
        .ent_vld  (alu_ent_vld)
    );

    wb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (mem_wr_valid),
        .push_dat ({mem_wr_addr, mem_wr_data}),
        .pop      (grant_mem),
        .head_dat (mem_head),
        .head_vld (mem_head_vld),
        .rdy      (mem_wr_ready),
        .ent_dat  (mem_ent),
        .ent_vld  (mem_ent_vld)
    );

    // rr_ptr names the source that wins a tie; a lone valid head always wins.
    assign grant_alu = alu_head_vld & (~mem_head_vld | ~rr_ptr);
    assign grant_mem = mem_head_vld & ~grant_alu;
    assign any_grant = alu_head_vld | mem_head_vld;
    assign sel_dat   = grant_mem ? mem_head : alu_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_src   <= 1'b0;
        end else begin
            wr_valid <= any_grant;
            if (any_grant) begin
                rr_ptr  <= ~grant_mem;
                wr_addr <= sel_dat[W-1 -: ADDR_W];
                wr_data <= sel_dat[DATA_W-1:0];
                wr_src  <= grant_mem;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_ent_vld[i]) busy_mask[alu_ent[i*W + DATA_W +: ADDR_W]] = 1'b1;
            if (mem_ent_vld[i]) busy_mask[mem_ent[i*W + DATA_W +: ADDR_W]] = 1'b1;
        end
        if (wr_valid) busy_mask[wr_addr] = 1'b1;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, contention, backpressure, wrap, mid-op reset.
module tb_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        alu_wr_valid;
    logic [3:0]  alu_wr_addr;
    logic [31:0] alu_wr_data;
    logic        alu_wr_ready;
    logic        mem_wr_valid;
    logic [3:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_src;
    logic [15:0] busy_mask;

    int n_chk  = 0;
    int n_pass = 0;

    wb_arbiter #(.ADDR_W(4), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .alu_wr_ready (alu_wr_ready),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_src       (wr_src),
        .busy_mask    (busy_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        alu_wr_valid = 1'b0;
        mem_wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int  a_i, m_i, a_w, m_w, got, pulses;
    bit  saw_stall, acc_a, acc_m;

    initial begin
        rst_n        = 1'b0;
        alu_wr_valid = 1'b1;
        alu_wr_addr  = 4'd9;
        alu_wr_data  = 32'h99;
        mem_wr_valid = 1'b1;
        mem_wr_addr  = 4'd10;
        mem_wr_data  = 32'hAA;

        // Reset held two edges with both requesters valid
        tick();
        tick();
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_alu_rdy", alu_wr_ready, 1);
        chk("rst_mem_rdy", mem_wr_ready, 1);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        alu_wr_valid = 1'b0;
        mem_wr_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        chk("rst_no_push_busy", busy_mask, 0);
        tick();
        chk("rst_no_push_wr", wr_valid, 0);

        // Single ALU write
        alu_wr_valid = 1'b1;
        alu_wr_addr  = 4'd3;
        alu_wr_data  = 32'hDEADBEEF;
        tick();
        alu_wr_valid = 1'b0;
        chk("single_e0_wr_valid", wr_valid, 0);
        chk("single_e0_busy", busy_mask, 16'h0008);
        tick();
        chk("single_wr_valid", wr_valid, 1);
        chk("single_wr_addr", wr_addr, 3);
        chk("single_wr_data", wr_data, 64'hDEADBEEF);
        chk("single_wr_src", wr_src, 0);
        chk("single_e1_busy", busy_mask, 16'h0008);
        tick();
        chk("single_e2_wr_valid", wr_valid, 0);
        chk("single_e2_busy", busy_mask, 0);
        chk("single_hold_data", wr_data, 64'hDEADBEEF);

        // Same-edge contention from a fresh rr_ptr
        do_reset();
        alu_wr_valid = 1'b1; alu_wr_addr = 4'd1; alu_wr_data = 32'h11;
        mem_wr_valid = 1'b1; mem_wr_addr = 4'd2; mem_wr_data = 32'h22;
        tick();
        alu_wr_valid = 1'b0;
        mem_wr_valid = 1'b0;
        chk("cont_busy0", busy_mask, 16'h0006);
        tick();
        chk("cont_w1", {wr_valid, wr_src, wr_addr, wr_data}, {1'b1, 1'b0, 4'd1, 32'h11});
        chk("cont_busy1", busy_mask, 16'h0006);
        tick();
        chk("cont_w2", {wr_valid, wr_src, wr_addr, wr_data}, {1'b1, 1'b1, 4'd2, 32'h22});
        chk("cont_busy2", busy_mask, 16'h0004);
        tick();
        chk("cont_idle", wr_valid, 0);
        chk("cont_busy3", busy_mask, 0);

        // Both sources continuously valid: strict alternation
        alu_wr_valid = 1'b1; alu_wr_addr = 4'd4; alu_wr_data = 32'h44;
        mem_wr_valid = 1'b1; mem_wr_addr = 4'd5; mem_wr_data = 32'h55;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt_src", {wr_valid, wr_src}, {1'b1, k[0]});
        end
        alu_wr_valid = 1'b0;
        mem_wr_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("alt_drain_wr", wr_valid, 0);
        chk("alt_drain_busy", busy_mask, 0);

        // Backpressure: 3 MEM requests while ALU also streams 3
        do_reset();
        a_i = 0; m_i = 0; a_w = 0; m_w = 0; saw_stall = 0;
        for (int c = 0; c < 20; c++) begin
            alu_wr_valid = (a_i < 3);
            alu_wr_addr  = 4'(11 + a_i);
            alu_wr_data  = 32'(32'hB0 + a_i);
            mem_wr_valid = (m_i < 3);
            mem_wr_addr  = 4'(8 + m_i);
            mem_wr_data  = 32'(32'hA0 + m_i);
            #0;
            if (mem_wr_valid && !mem_wr_ready) saw_stall = 1;
            acc_a = alu_wr_valid & alu_wr_ready;
            acc_m = mem_wr_valid & mem_wr_ready;
            tick();
            if (acc_a) a_i++;
            if (acc_m) m_i++;
            if (wr_valid) begin
                if (!wr_src) begin
                    chk("bp_alu_word", {wr_addr, wr_data}, {4'(11 + a_w), 32'(32'hB0 + a_w)});
                    a_w++;
                end else begin
                    chk("bp_mem_word", {wr_addr, wr_data}, {4'(8 + m_w), 32'(32'hA0 + m_w)});
                    m_w++;
                end
            end
        end
        alu_wr_valid = 1'b0;
        mem_wr_valid = 1'b0;
        chk("bp_alu_count", a_w, 3);
        chk("bp_mem_count", m_w, 3);
        chk("bp_mem_stall_seen", saw_stall, 1);
        chk("bp_final_busy", busy_mask, 0);

        // Wrap-around: 6 sequential ALU writes
        do_reset();
        a_i = 0; got = 0;
        for (int c = 0; c < 16; c++) begin
            alu_wr_valid = (a_i < 6);
            alu_wr_addr  = 4'(a_i);
            alu_wr_data  = 32'(32'h100 + a_i);
            #0;
            acc_a = alu_wr_valid & alu_wr_ready;
            tick();
            if (acc_a) a_i++;
            if (wr_valid) begin
                chk("wrap_word", {wr_src, wr_addr, wr_data}, {1'b0, 4'(got), 32'(32'h100 + got)});
                chk("wrap_cycle", c, got + 1);
                got++;
            end
        end
        alu_wr_valid = 1'b0;
        chk("wrap_count", got, 6);

        // Reset with both FIFOs holding entries
        do_reset();
        alu_wr_valid = 1'b1; alu_wr_addr = 4'd6; alu_wr_data = 32'h66;
        mem_wr_valid = 1'b1; mem_wr_addr = 4'd7; mem_wr_data = 32'h77;
        tick();
        tick();
        tick();
        chk("mid_busy_pre", busy_mask, 16'h00C0);
        rst_n        = 1'b0;
        alu_wr_valid = 1'b0;
        mem_wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_wr_valid", wr_valid, 0);
        chk("mid_busy", busy_mask, 0);
        chk("mid_rdy", {alu_wr_ready, mem_wr_ready}, 2'b11);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (wr_valid) pulses++;
        end
        chk("mid_no_pulses", pulses, 0);
        chk("mid_busy_after", busy_mask, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
